// File: rtl/data_mem_if.sv
// Memory-stage bus interface: turns a single-cycle load/store into a req/ack
// transaction on a slow data memory, stalling the pipeline until it completes.
module data_mem_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  input  logic        err_clr,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            access;
  logic            aligned;
  logic            timeout;
  logic            err_set;

  always_comb begin
    access   = memread | memwrite;
    aligned  = (addr[1:0] == 2'b00);
    timeout  = (cnt == CW'(TIMEOUT - 1));
    state_nx = state;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            state_nx = REQ;
          end else begin
            state_nx = DONE;
            err_set  = 1'b1;
          end
        end
      end
      REQ: begin
        if (m_ack) begin
          state_nx = DONE;
        end else if (timeout) begin
          state_nx = DONE;
          err_set  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gated by reset so the pipeline is released in the same cycle reset asserts.
  always_comb begin
    stall = reset & (((state == IDLE) & access) | (state == REQ));
    m_req = (state == REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata <= '0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              m_addr  <= addr;
              m_wdata <= wdata;
              m_we    <= memwrite;
              cnt     <= '0;
            end else begin
              readdata <= '0;
            end
          end
        end
        REQ: begin
          if (m_ack) begin
            if (!m_we) readdata <= m_rdata;
          end else if (timeout) begin
            if (!m_we) readdata <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
